// File: rtl/ed25519_pkg.sv
// Shared SHA-512 constants, FSM state type and bit-twiddling helpers for the
// Ed25519 seed-hashing datapath.
package ed25519_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FIN,
    S_DONE
  } sha_state_e;

  localparam logic [63:0] SHA512_K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [63:0] SHA512_IV [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // Byte reversal: converts between the little-endian bus packing and SHA-512 words.
  function automatic logic [63:0] be64(input logic [63:0] x);
    logic [63:0] r;
    for (int unsigned i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  function automatic logic [63:0] bsig0(input logic [63:0] x);
    return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
  endfunction

  function automatic logic [63:0] bsig1(input logic [63:0] x);
    return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
  endfunction

endpackage

// File: rtl/sha512_round.sv
// One combinational SHA-512 compression round; index 0 of the state vector is 'a'.
module sha512_round
  import ed25519_pkg::*;
(
  input  logic [7:0][63:0] i_v,
  input  logic [63:0]      i_k,
  input  logic [63:0]      i_w,
  output logic [7:0][63:0] o_v
);

  logic [63:0] w_ch;
  logic [63:0] w_maj;
  logic [63:0] w_t1;
  logic [63:0] w_t2;

  always_comb begin
    w_ch  = (i_v[4] & i_v[5]) ^ (~i_v[4] & i_v[6]);
    w_maj = (i_v[0] & i_v[1]) ^ (i_v[0] & i_v[2]) ^ (i_v[1] & i_v[2]);
    w_t1  = i_v[7] + bsig1(i_v[4]) + w_ch + i_k + i_w;
    w_t2  = bsig0(i_v[0]) + w_maj;
    o_v[0] = w_t1 + w_t2;
    o_v[1] = i_v[0];
    o_v[2] = i_v[1];
    o_v[3] = i_v[2];
    o_v[4] = i_v[3] + w_t1;
    o_v[5] = i_v[4];
    o_v[6] = i_v[5];
    o_v[7] = i_v[6];
  end

endmodule

// File: rtl/seed_sha512.sv
// Iterative SHA-512 over a 32-byte Ed25519 seed: one padded block, one round per clock,
// digest presented little-endian-packed for the combinational clamp stage.
module seed_sha512
  import ed25519_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] seed_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] digest_o,
  output logic         busy
);

  sha_state_e       r_state;
  sha_state_e       w_next;
  logic [6:0]       r_rnd;
  logic [15:0][63:0] r_w;
  logic [7:0][63:0] r_v;
  logic [7:0][63:0] w_v_next;
  logic [511:0]     r_digest;
  logic [63:0]      w_k;
  logic [63:0]      w_wnew;

  // Window holds W[t..t+15] during round t; the tail entry becomes W[t+16].
  assign w_k    = SHA512_K[r_rnd];
  assign w_wnew = sig1(r_w[14]) + r_w[9] + sig0(r_w[1]) + r_w[0];

  sha512_round u_round (
    .i_v (r_v),
    .i_k (w_k),
    .i_w (r_w[0]),
    .o_v (w_v_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (r_rnd == 7'd79) w_next = S_FIN;
      end
      S_FIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd    <= '0;
      r_w      <= '0;
      r_v      <= '0;
      r_digest <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_w[0]    <= be64(seed_i[63:0]);
          r_w[1]    <= be64(seed_i[127:64]);
          r_w[2]    <= be64(seed_i[191:128]);
          r_w[3]    <= be64(seed_i[255:192]);
          r_w[4]    <= 64'h8000_0000_0000_0000;
          r_w[14:5] <= '0;
          r_w[15]   <= 64'd256;
          r_v       <= {SHA512_IV[7], SHA512_IV[6], SHA512_IV[5], SHA512_IV[4],
                        SHA512_IV[3], SHA512_IV[2], SHA512_IV[1], SHA512_IV[0]};
          r_rnd     <= '0;
        end
        S_ROUND: begin
          r_v   <= w_v_next;
          r_w   <= {w_wnew, r_w[15:1]};
          r_rnd <= r_rnd + 7'd1;
        end
        S_FIN: begin
          for (int unsigned j = 0; j < 8; j++)
            r_digest[64*j +: 64] <= be64(SHA512_IV[j] + r_v[j]);
        end
        S_DONE: if (out_ready && ZEROIZE) begin
          r_w      <= '0;
          r_v      <= '0;
          r_digest <= '0;
        end
        default: ;
      endcase
    end
  end

  assign digest_o = r_digest;

endmodule

// File: tb/tb_seed_sha512.sv
// Self-checking bench for seed_sha512 against an independent full-schedule SHA-512 model.
module tb_seed_sha512;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [255:0] seed_i;
  logic         in_ready, out_valid, busy;
  logic [511:0] digest_o;
  logic         in_ready0, out_valid0, busy0;
  logic [511:0] digest0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seed_sha512 #(.ZEROIZE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .seed_i(seed_i),
    .out_valid(out_valid), .out_ready(out_ready), .digest_o(digest_o), .busy(busy)
  );

  seed_sha512 #(.ZEROIZE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .seed_i(seed_i),
    .out_valid(out_valid0), .out_ready(out_ready), .digest_o(digest0), .busy(busy0)
  );

  localparam logic [63:0] TB_K [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [63:0] TB_IV [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [511:0] ABC_GOLD =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

  typedef struct {
    logic [255:0] seed;
    bit           tog;
    logic [511:0] exp;
  } vec_t;

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [63:0] ss0(input logic [63:0] x); return rr(x, 1) ^ rr(x, 8) ^ (x >> 7); endfunction
  function automatic logic [63:0] ss1(input logic [63:0] x); return rr(x, 19) ^ rr(x, 61) ^ (x >> 6); endfunction
  function automatic logic [63:0] bs0(input logic [63:0] x); return rr(x, 28) ^ rr(x, 34) ^ rr(x, 39); endfunction
  function automatic logic [63:0] bs1(input logic [63:0] x); return rr(x, 14) ^ rr(x, 18) ^ rr(x, 41); endfunction

  // Single-block SHA-512; block and result are big-endian byte streams (byte 0 at MSB).
  function automatic logic [511:0] sha_model(input logic [1023:0] blk);
    logic [63:0] w [0:79];
    logic [63:0] v [0:7];
    logic [63:0] t1, t2;
    logic [511:0] h;
    for (int t = 0; t < 16; t++) w[t] = blk[1023 - 64*t -: 64];
    for (int t = 16; t < 80; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
    for (int j = 0; j < 8; j++) v[j] = TB_IV[j];
    for (int t = 0; t < 80; t++) begin
      t1 = v[7] + bs1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[t] + w[t];
      t2 = bs0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) h[511 - 64*j -: 64] = v[j] + TB_IV[j];
    return h;
  endfunction

  function automatic logic [1023:0] seed_blk(input logic [255:0] s);
    logic [1023:0] b;
    b = '0;
    for (int k = 0; k < 32; k++) b[1023 - 8*k -: 8] = s[8*k +: 8];
    b[767:760] = 8'h80;
    b[15:0]    = 16'h0100;
    return b;
  endfunction

  function automatic logic [511:0] to_le512(input logic [511:0] h);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = h[511 - 8*k -: 8];
    return r;
  endfunction

  function automatic logic [255:0] to_le256(input logic [255:0] b);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = b[255 - 8*k -: 8];
    return r;
  endfunction

  function automatic logic [511:0] golden(input logic [255:0] s);
    return to_le512(sha_model(seed_blk(s)));
  endfunction

  function automatic logic [255:0] clamp(input logic [255:0] x);
    logic [255:0] r;
    r = x;
    r[2:0] = 3'b000;
    r[255] = 1'b0;
    r[254] = 1'b1;
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts one seed and waits (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic run_hash(input logic [255:0] s, input bit tog, output int lat, output logic [511:0] d);
    @(negedge clk);
    check("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    seed_i   = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    check("in_ready_drop", in_ready, 0);
    check("busy_rise", busy, 1);
    while (!out_valid && lat < 200) begin
      if (tog) begin
        in_valid = ~in_valid;
        seed_i   = rnd256();
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    d = digest_o;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int lat;
    int cnt;
    logic [511:0] d;
    logic [255:0] s;
    logic [1023:0] abc;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seed_i = '0;
    #1 rst_n = 1'b0;

    abc = '0;
    abc[1023 -: 32] = 32'h61626380;
    abc[7:0] = 8'h18;
    check("model_abc", sha_model(abc), ABC_GOLD);

    #10;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digest", digest_o, '0);
    check("rst_rnd", dut.r_rnd, 0);
    check("rst_w", |dut.r_w, 0);
    check("rst_v", |dut.r_v, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0].seed = '0;          tbl[0].tog = 1'b0;
    tbl[1].seed = to_le256(256'h9d61b19deffd5a60ba844af492ec2cc44449c5697b326919703bac031cae7f60);
    tbl[1].tog  = 1'b0;
    tbl[2].seed = to_le256(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    tbl[2].tog  = 1'b1;
    tbl[3].seed = {8{32'hdeadbeef}}; tbl[3].tog = 1'b1;
    for (int i = 0; i < 4; i++) tbl[i].exp = golden(tbl[i].seed);

    for (int i = 0; i < 4; i++) begin
      run_hash(tbl[i].seed, tbl[i].tog, lat, d);
      check("latency", lat, 81);
      check("digest", d, tbl[i].exp);
      if (i == 1) check("clamp_scalar", clamp(d[255:0]), clamp(tbl[i].exp[255:0]));
      if (i == 0) begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          check("bp_out_valid", out_valid, 1);
          check("bp_digest", digest_o, d);
          check("bp_in_ready", in_ready, 0);
        end
      end
      handshake();
      check("zeroize_digest", digest_o, '0);
      check("zeroize_w", |dut.r_w, 0);
      check("zeroize_v", |dut.r_v, 0);
      check("hold_digest_nozero", digest0, tbl[i].exp);
    end

    // Abort at round 40, then make sure the engine recovers cleanly.
    s = rnd256();
    @(negedge clk);
    in_valid = 1'b1; seed_i = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_digest", digest_o, '0);
    check("abort_rnd", dut.r_rnd, 0);
    check("abort_w", |dut.r_w, 0);
    check("abort_v", |dut.r_v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_abort_out_valid", out_valid, 0);
    end
    run_hash({256{1'b1}}, 1'b0, lat, d);
    check("ff_latency", lat, 81);
    check("ff_digest", d, golden({256{1'b1}}));
    handshake();

    // Back-to-back random seeds with the consumer always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    seed_i    = rnd256();
    for (int i = 0; i < 200; i++) begin
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 300) begin @(negedge clk); cnt++; end
      check("rand_accept", in_ready, 1);
      s = seed_i;
      @(posedge clk); #1;
      seed_i = rnd256();
      cnt = 0;
      while (!out_valid && cnt < 300) begin @(negedge clk); cnt++; end
      check("rand_digest", digest_o, golden(s));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
